// File: rtl/div3_serial.sv
// div3_serial: sequential divide-by-3 unit.
//
// Accepts an unsigned WIDTH-bit dividend over a valid/ready handshake and
// walks it MSB first, one bit per clock, keeping a running residue r in
// {0,1,2}. Each step forms t = 2r + b; the quotient bit is (t >= 3) and the
// new residue is t mod 3. After WIDTH steps the full quotient and remainder
// are registered and offered over a second valid/ready handshake.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   in_valid   dividend on `in` is valid
//   in_ready   block can accept a dividend (IDLE only)
//   in         unsigned dividend
//   out_valid  quotient/remainder valid (DONE only)
//   out_ready  consumer accepts the result
//   quotient   floor(in / 3), held until the next result or reset
//   remainder  in mod 3 (0..2), held until the next result or reset
//   busy       high in RUN or DONE
module div3_serial #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] quotient,
    output logic [1:0]       remainder,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] shreg;
    logic [WIDTH-1:0] qwork;
    logic [1:0]       r;
    logic [CW-1:0]    cnt;

    // One long-division step in base 2 against divisor 3. Since r <= 2,
    // 2r + b is just {r, b} and never exceeds 5.
    logic [2:0] t;
    logic       qbit;
    logic [1:0] r_nxt;

    always_comb begin
        t     = {r, shreg[WIDTH-1]};
        qbit  = (t >= 3'd3);
        r_nxt = qbit ? 2'(t - 3'd3) : t[1:0];
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (in_valid)          state_nxt = RUN;
            RUN:     if (cnt == '0)         state_nxt = DONE;
            DONE:    if (out_ready)         state_nxt = IDLE;
            default:                        state_nxt = IDLE;
        endcase
    end

    // Outputs are pure decodes of the state register
    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
        busy      = (state == RUN) || (state == DONE);
    end

    // Datapath
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shreg     <= '0;
            qwork     <= '0;
            r         <= '0;
            cnt       <= '0;
            quotient  <= '0;
            remainder <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        shreg <= in;
                        qwork <= '0;
                        r     <= '0;
                        cnt   <= CW'(WIDTH - 1);
                    end
                end
                RUN: begin
                    shreg <= {shreg[WIDTH-2:0], 1'b0};
                    qwork <= {qwork[WIDTH-2:0], qbit};
                    r     <= r_nxt;
                    cnt   <= cnt - CW'(1);
                    // Last bit: publish the result; outputs otherwise hold
                    if (cnt == '0) begin
                        quotient  <= {qwork[WIDTH-2:0], qbit};
                        remainder <= r_nxt;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_div3_serial.sv
// Self-checking bench for div3_serial: table-driven vectors at WIDTH=32,
// hand-written sequences for backpressure, ignored input, async reset and
// back-to-back throughput, plus a small WIDTH=2 instance.
module tb_div3_serial;

    localparam int W = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid, in_ready, out_valid, out_ready, busy;
    logic [W-1:0]  din, quotient;
    logic [1:0]    remainder;

    logic          s_in_valid, s_in_ready, s_out_valid, s_out_ready, s_busy;
    logic [1:0]    s_din, s_quotient, s_remainder;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    div3_serial #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in(din),
        .out_valid(out_valid), .out_ready(out_ready),
        .quotient(quotient), .remainder(remainder), .busy(busy)
    );

    div3_serial #(.WIDTH(2)) dut2 (
        .clk(clk), .rst(rst),
        .in_valid(s_in_valid), .in_ready(s_in_ready), .in(s_din),
        .out_valid(s_out_valid), .out_ready(s_out_ready),
        .quotient(s_quotient), .remainder(s_remainder), .busy(s_busy)
    );

    typedef struct {
        logic [31:0] din;
        logic [31:0] q;
        logic [1:0]  r;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full transaction on the WIDTH=32 instance
    task automatic run_op(input logic [31:0] d, input logic [31:0] q, input logic [1:0] r,
                          input string name);
        int lat;
        chk({name, " in_ready"}, 64'(in_ready), 64'd1);
        din = d; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 100) begin
            tick();
            lat++;
        end
        chk({name, " latency"}, 64'(lat), 64'(W));
        chk({name, " quotient"}, 64'(quotient), 64'(q));
        chk({name, " remainder"}, 64'(remainder), 64'(r));
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk({name, " back to idle"}, 64'({out_valid, in_ready}), 64'b01);
    endtask

    task automatic run2(input logic [1:0] d, input logic [1:0] q, input logic [1:0] r,
                        input string name);
        int lat;
        s_din = d; s_in_valid = 1'b1;
        tick();
        s_in_valid = 1'b0;
        lat = 0;
        while (!s_out_valid && lat < 20) begin
            tick();
            lat++;
        end
        chk({name, " latency"}, 64'(lat), 64'd2);
        chk({name, " quotient"}, 64'(s_quotient), 64'(q));
        chk({name, " remainder"}, 64'(s_remainder), 64'(r));
        s_out_ready = 1'b1;
        tick();
        s_out_ready = 1'b0;
        chk({name, " idle"}, 64'(s_in_ready), 64'd1);
    endtask

    vec_t vecs[6];

    initial begin
        logic [31:0] hold_q;
        logic [1:0]  hold_r;
        int          lat, stable_bad;

        vecs[0] = '{32'h0000_0000, 32'h0000_0000, 2'd0};
        vecs[1] = '{32'h0000_0007, 32'h0000_0002, 2'd1};
        vecs[2] = '{32'h0000_0064, 32'h0000_0021, 2'd1};
        vecs[3] = '{32'hFFFF_FFFF, 32'h5555_5555, 2'd0};
        vecs[4] = '{32'hFFFF_FFFE, 32'h5555_5554, 2'd2};
        vecs[5] = '{32'h8000_0000, 32'h2AAA_AAAA, 2'd2};

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; din = '0;
        s_in_valid = 1'b0; s_out_ready = 1'b0; s_din = '0;
        #1;
        chk("reset state", 64'({in_ready, out_valid, busy, quotient, remainder}),
            64'({1'b1, 1'b0, 1'b0, 32'd0, 2'd0}));
        tick();
        rst = 1'b0;

        // Table vectors
        for (int i = 0; i < 6; i++)
            run_op(vecs[i].din, vecs[i].q, vecs[i].r, $sformatf("vec%0d", i));

        // Backpressure: hold DONE for 10 cycles
        din = 32'd100; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 100) begin tick(); lat++; end
        chk("bp latency", 64'(lat), 64'(W));
        hold_q = quotient; hold_r = remainder;
        stable_bad = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (!out_valid || quotient !== hold_q || remainder !== hold_r) stable_bad++;
        end
        chk("bp hold stable", 64'(stable_bad), 64'd0);
        chk("bp result", 64'({quotient, remainder}), 64'({32'h21, 2'd1}));
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("bp release", 64'({out_valid, in_ready, busy}), 64'b010);

        // in_valid toggling with new data during RUN is ignored
        din = 32'd7; in_valid = 1'b1;
        tick();
        lat = 0;
        while (!out_valid && lat < 100) begin
            in_valid = ~in_valid;
            din = 32'h1234 + 32'(lat);
            tick();
            lat++;
        end
        in_valid = 1'b0;
        chk("ign latency", 64'(lat), 64'(W));
        chk("ign result", 64'({quotient, remainder}), 64'({32'd2, 2'd1}));
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        // Asynchronous reset mid-RUN
        din = 32'h1234_5678; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        chk("pre-reset busy", 64'(busy), 64'd1);
        #2 rst = 1'b1;
        #1;
        chk("async reset", 64'({in_ready, out_valid, busy, quotient, remainder}),
            64'({1'b1, 1'b0, 1'b0, 32'd0, 2'd0}));
        in_valid = 1'b1;
        tick();
        chk("no accept in reset", 64'(busy), 64'd0);
        in_valid = 1'b0;
        rst = 1'b0;
        run_op(32'd9, 32'd3, 2'd0, "after reset");

        // Back-to-back sweep with out_ready high, wrapping through zero
        begin
            logic [31:0] nxt, q_exp[$];
            int cyc, last_acc, n_acc, n_chk, gap_bad;
            logic acc;
            nxt = 32'hFFFF_FFFF - 32'd40;
            out_ready = 1'b1; in_valid = 1'b1; din = nxt;
            cyc = 0; last_acc = -1; n_acc = 0; n_chk = 0; gap_bad = 0;
            while (n_chk < 61 && cyc < 5000) begin
                acc = in_ready && in_valid;
                tick();
                cyc++;
                if (acc) begin
                    if (last_acc >= 0 && cyc - last_acc != W + 2) gap_bad++;
                    last_acc = cyc;
                    q_exp.push_back(din);
                    n_acc++;
                    nxt = nxt + 32'd1;
                    din = nxt;
                    if (n_acc == 61) in_valid = 1'b0;
                end
                if (out_valid && q_exp.size() > 0) begin
                    logic [31:0] d;
                    d = q_exp.pop_front();
                    chk($sformatf("sweep %0h", d), 64'({quotient, remainder}),
                        64'({d / 32'd3, 2'(d % 32'd3)}));
                    n_chk++;
                end
            end
            in_valid = 1'b0; out_ready = 1'b0;
            chk("sweep count", 64'(n_chk), 64'd61);
            chk("sweep spacing", 64'(gap_bad), 64'd0);
            tick();
        end

        // WIDTH=2 instance
        run2(2'd3, 2'd1, 2'd0, "w2 in3");
        run2(2'd2, 2'd0, 2'd2, "w2 in2");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
